ospfb_phase_sequencer: RTL
==========================

// Module: ospfb_phase_sequencer
// PURPOSE
//   Front-end sequencer for the OSPFB. Generalises the decimator-phase controller to any
//   DEC_FAC <= FFT_LEN, with a run-time enable, an underrun-recovery path and an AXIS handshake
//   on the FFT config load. It tracks the commutator phase and gates input beats into the
//   re/im FIR datapaths. It drives the FIR/phasecomp hold reset and flags FEEDBACK phases.
// PARAMETERS
//   WIDTH       16  bits per real/imag input component
//   FFT_LEN     32  polyphase branches / FFT length (power of 2)
//   DEC_FAC     24  decimation factor, 1 <= DEC_FAC <= FFT_LEN
//   SRT_PHA     23  phase of the first accepted sample, SRT_PHA < DEC_FAC
//   RESYNC_CYC  64  cycles hold_rst is held after an underrun (pipeline flush), >= 1
//   CONF_WID    8   FFT config word width
//   CNT_WID     16  underrun counter width
// PORTS
//   clk            in   1            clock
//   rst            in   1            synchronous active-high reset
//   en             in   1            advance enable; 0 freezes the sequencer
//   s_axis_tdata   in   2*WIDTH      {im, re} input sample
//   s_axis_tvalid  in   1            input valid
//   s_axis_tready  out  1            input ready (combinational)
//   cfg_word       in   CONF_WID     FFT config word, sampled at start
//   cfg_tdata      out  CONF_WID     FFT config channel data
//   cfg_tvalid     out  1            FFT config channel valid
//   cfg_tready     in   1            FFT config channel ready
//   vin            out  1            registered: sample valid to FIR datapaths
//   din_re/din_im  out  WIDTH each   registered sample components
//   hold_rst       out  1            registered reset to FIR/phasecomp
//   modtimer       out  log2(FFT_LEN) current commutator phase
//   feedback       out  1            modtimer >= DEC_FAC while RUN
//   frame_last     out  1            modtimer == FFT_LEN-1 while RUN (FFT tlast source)
//   underrun       out  1            one-cycle pulse on detected underrun
//   underrun_cnt   out  CNT_WID      saturating underrun count
// BEHAVIOUR
//   Reset values
//   - State IDLE; modtimer=SRT_PHA; hold_rst=1.
//   - vin=0; din=0; cfg_tvalid=0; cfg_tdata=0; underrun=0; underrun_cnt=0.
//   - s_axis_tready=0 while rst=1.
//   States
//   - IDLE: hold_rst=1 and s_axis_tready=en.
//     - On accept: vin=1 and din=tdata next cycle; hold_rst=0 next cycle.
//     - Also on accept: modtimer->SRT_PHA+1 (mod FFT_LEN), cfg_tdata<=cfg_word, cfg_tvalid<=1,
//       go to RUN.
//   - RUN: when en=1, modtimer increments and wraps FFT_LEN-1 -> 0.
//     - s_axis_tready = en & (modtimer < DEC_FAC).
//     - Accepted beat gives vin=1 and din=tdata one cycle later; otherwise vin=0 and din holds.
//     - If tready=1 and tvalid=0: underrun pulse next cycle; underrun_cnt+1 (saturates at all-ones).
//       In the same step, hold_rst<=1, modtimer<=SRT_PHA, go to RESYNC.
//   - RESYNC: hold_rst=1, tready=0; count RESYNC_CYC cycles, then go to IDLE.
//   Latency and handshake
//   - Latency from input accept to vin/din is 1 cycle.
//   - cfg_tvalid stays 1 with cfg_tdata stable until cfg_tready=1, then drops the next cycle.
//   - The cfg handshake is independent of state and survives RESYNC.
//   Boundary conditions
//   - en=0: modtimer, state and counters freeze; tready=0; vin=0; no underrun check.
//   - rst dominates every event, including a mid-RUN or mid-cfg handshake.
//   - DEC_FAC==FFT_LEN: tready=en in RUN and feedback is never asserted.
//   - feedback and frame_last are 0 outside RUN.
//   - SRT_PHA >= DEC_FAC or DEC_FAC > FFT_LEN: elaboration-time $error.
// TESTING (defaults unless noted)
//   1. Reset, then tvalid=1 always, en=1.
//      -> First accept in IDLE; hold_rst falls 1 cycle later.
//      -> tready=0 for 8 cycles (phases 24..31), then 1 for 24; repeats.
//      -> vin count after 100 frames = 1 + 2400; underrun_cnt=0.
//   2. tvalid=0 on one cycle with modtimer=5 in RUN.
//      -> underrun pulse, underrun_cnt=1, hold_rst=1 for 64 cycles, modtimer=23.
//      -> Next tvalid restarts from IDLE.
//   3. en=0 for 10 cycles at modtimer=12.
//      -> modtimer stays 12, tready=0, vin=0, no underrun; resumes at 13.
//   4. cfg_word=8'h5A, cfg_tready=0 for 3 cycles after start.
//      -> cfg_tvalid=1 for 4 cycles, cfg_tdata=8'h5A throughout, then 0.
//   5. DEC_FAC=32, SRT_PHA=31.
//      -> After start, tready=1 every RUN cycle, feedback=0, frame_last every 32 cycles.
//   6. rst asserted mid-RUN at modtimer=20.
//      -> Next cycle every output equals its reset value; underrun_cnt=0.

Source files
------------

// File: rtl/ospfb_phase_sequencer_if.sv
// Stream-side bundle of the OSPFB phase sequencer: the AXIS sample input
// and the AXIS FFT configuration output.
interface ospfb_phase_sequencer_if #(
    parameter int WIDTH    = 16,
    parameter int CONF_WID = 8
);
    logic [2*WIDTH-1:0]  s_axis_tdata;
    logic                s_axis_tvalid;
    logic                s_axis_tready;
    logic [CONF_WID-1:0] cfg_tdata;
    logic                cfg_tvalid;
    logic                cfg_tready;

    // Upstream sample source that also consumes the FFT config channel
    modport master (
        output s_axis_tdata, s_axis_tvalid, cfg_tready,
        input  s_axis_tready, cfg_tdata, cfg_tvalid
    );

    // Sequencer side: sinks samples, sources the FFT config word
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, cfg_tready,
        output s_axis_tready, cfg_tdata, cfg_tvalid
    );
endinterface

// File: rtl/ospfb_phase_sequencer.sv
// OSPFB front-end sequencer: tracks the commutator phase, gates input beats
// into the re/im FIR datapaths, drives the FIR/phasecomp hold reset, flags
// feedback phases and recovers from input underruns via a flush period.
module ospfb_phase_sequencer #(
    parameter int WIDTH      = 16,
    parameter int FFT_LEN    = 32,
    parameter int DEC_FAC    = 24,
    parameter int SRT_PHA    = 23,
    parameter int RESYNC_CYC = 64,
    parameter int CONF_WID   = 8,
    parameter int CNT_WID    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    ospfb_phase_sequencer_if.slave     bus,
    input  logic [CONF_WID-1:0]        cfg_word,
    output logic                       vin,
    output logic [WIDTH-1:0]           din_re,
    output logic [WIDTH-1:0]           din_im,
    output logic                       hold_rst,
    output logic [$clog2(FFT_LEN)-1:0] modtimer,
    output logic                       feedback,
    output logic                       frame_last,
    output logic                       underrun,
    output logic [CNT_WID-1:0]         underrun_cnt
);
    localparam int MT_WID = $clog2(FFT_LEN);
    localparam int RC_WID = (RESYNC_CYC > 1) ? $clog2(RESYNC_CYC) : 1;

    // One extra bit so DEC_FAC == FFT_LEN stays representable and the
    // "phase open" compare is simply always true in that configuration.
    localparam logic [MT_WID:0]   DEC_EXT   = (MT_WID+1)'(DEC_FAC);
    localparam logic [MT_WID-1:0] SRT_MT    = MT_WID'(SRT_PHA);
    localparam logic [MT_WID-1:0] START_MT  = MT_WID'((SRT_PHA + 1) % FFT_LEN);
    localparam logic [MT_WID-1:0] LAST_MT   = MT_WID'(FFT_LEN - 1);
    localparam logic [RC_WID-1:0] RC_LAST   = RC_WID'(RESYNC_CYC - 1);

    if (DEC_FAC < 1 || DEC_FAC > FFT_LEN || SRT_PHA < 0 || SRT_PHA >= DEC_FAC ||
        (FFT_LEN & (FFT_LEN - 1)) != 0 || RESYNC_CYC < 1) begin : g_param_check
        $error("ospfb_phase_sequencer: illegal FFT_LEN/DEC_FAC/SRT_PHA/RESYNC_CYC");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RESYNC = 2'd2
    } state_t;

    state_t              state;
    logic [RC_WID-1:0]   resync_cnt;
    logic                tready;
    logic                accept;
    logic                phase_open;
    logic                in_run;
    logic [CONF_WID-1:0] cfg_tdata_q;
    logic                cfg_tvalid_q;

    assign in_run     = (state == RUN);
    assign phase_open = ({1'b0, modtimer} < DEC_EXT);
    assign feedback   = in_run && !phase_open;
    assign frame_last = in_run && (modtimer == LAST_MT);

    // Input ready: open in IDLE, or in RUN during the decimated phases; never in reset
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        tready = 1'b0;
        if (!rst && en) begin
            case (state)
                IDLE:    tready = 1'b1;
                RUN:     tready = phase_open;
                default: tready = 1'b0;
            endcase
        end
    end

    assign accept            = tready && bus.s_axis_tvalid;
    assign bus.s_axis_tready = tready;
    assign bus.cfg_tdata     = cfg_tdata_q;
    assign bus.cfg_tvalid    = cfg_tvalid_q;

    // Sequencer FSM with registered sample path, cfg handshake and underrun tracking
    // NOTE: non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            modtimer     <= SRT_MT;
            hold_rst     <= 1'b1;
            resync_cnt   <= '0;
            vin          <= 1'b0;
            din_re       <= '0;
            din_im       <= '0;
            cfg_tdata_q  <= '0;
            cfg_tvalid_q <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= 1'b0;
            vin      <= accept;
            if (accept) begin
                din_re <= bus.s_axis_tdata[WIDTH-1:0];
                din_im <= bus.s_axis_tdata[2*WIDTH-1:WIDTH];
            end

            // Config channel completes independently of the sequencer state
            if (cfg_tvalid_q && bus.cfg_tready) begin
                cfg_tvalid_q <= 1'b0;
            end

            if (en) begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            hold_rst     <= 1'b0;
                            modtimer     <= START_MT;
                            cfg_tdata_q  <= cfg_word;
                            cfg_tvalid_q <= 1'b1;
                            state        <= RUN;
                        end
                    end
                    RUN: begin
                        if (tready && !bus.s_axis_tvalid) begin
                            underrun   <= 1'b1;
                            if (underrun_cnt != '1) begin
                                underrun_cnt <= underrun_cnt + 1'b1;
                            end
                            hold_rst   <= 1'b1;
                            modtimer   <= SRT_MT;
                            resync_cnt <= '0;
                            state      <= RESYNC;
                        end else begin
                            modtimer <= modtimer + 1'b1;
                        end
                    end
                    RESYNC: begin
                        if (resync_cnt == RC_LAST) begin
                            resync_cnt <= '0;
                            state      <= IDLE;
                        end else begin
                            resync_cnt <= resync_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
